serial_pattern_detector: RTL and testbench
==========================================

# serial_pattern_detector

Parametrised serial bit-pattern detector, the next-generation successor to the team's fixed-pattern sequence detectors. It samples a qualified serial input stream and compares the last N bits against a runtime-loadable N-bit pattern. On a hit it raises a one-cycle match pulse, with overlapping or non-overlapping detection selectable at runtime. It also exposes the N-bit input history as a parallel output and keeps a saturating match counter. It sits between a serial receiver front end and control logic that reacts to framing or sync words.

## Interface
- N, 3: pattern length in bits; legal range N ≥ 2.
- CNT_W, 8: width of match counter.
- PAT_RST, 3'b110 (N bits): pattern value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- str_in  in  1  serial data bit.
- in_valid  in  1  str_in qualified this cycle.
- pattern  in  N  new pattern; pattern[N-1] is the first bit received, pattern[0] the last.
- pat_load  in  1  load pattern this cycle.
- overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- cnt_clr  in  1  clear match counter.
- str_out  out  N  bit history; str_out[0] is the newest accepted bit.
- match  out  1  one-cycle registered hit pulse.
- match_cnt  out  CNT_W  saturating count of hits.

## Operation
**Internal state**
- hist[N-1:0], drives str_out.
- pat_reg[N-1:0].
- fill: count of valid bits since the last clear, saturating at N, width clog2(N+1).
- match and match_cnt registers.

**Reset** (rst = 0 at an edge)
- hist = 0, fill = 0, pat_reg = PAT_RST, match = 0, match_cnt = 0.
- All other inputs are ignored that edge.

**Accept**
- A bit is accepted on an edge where rst = 1 and in_valid = 1.
- On accept: hist ← {hist[N-2:0], str_in}.
- When in_valid = 0, hist, fill and str_out hold.

**Hit condition**
- hit = accept && !pat_load && fill ≥ N-1 && {hist[N-2:0], str_in} == pat_reg.

**Next fill**
- pat_load = 1: fill ← 0. The bit is still shifted into hist, but a hit is impossible that edge.
- hit && overlap = 0: fill ← 0. History is retained but must be fully refilled, so no bit participates in two matches.
- Otherwise, on accept: fill ← min(fill+1, N).

**Other updates**
- pat_load = 1: pat_reg ← pattern. The new pattern applies to comparisons from the next edge.
- match ← hit.
- match_cnt:
  - cnt_clr = 1: match_cnt ← (hit ? 1 : 0).
  - Else, if hit and match_cnt < 2^CNT_W−1: match_cnt ← match_cnt+1.
  - Otherwise match_cnt holds.
- overlap is sampled per edge. Changing it mid-stream affects only the hit on that edge.

## Timing
**Latency**
- The completing bit is sampled at edge k; match is high from edge k until edge k+1.
- match_cnt updates at the same edge k.
- str_out reflects an accepted bit one edge after sampling.

**Pulse shape**
- match is never high for two consecutive cycles unless two consecutive accepted bits both complete a hit. That is possible only with overlap = 1 and a self-overlapping pattern such as all-ones.

**Boundary cases**
- Stalls: in_valid gaps of any length do not break a partial match.
- Startup: no match is possible until N bits have been accepted after reset or after pat_load.
- Reset mid-stream: a partially received pattern is discarded; a full N bits are required afterwards.
- Simultaneous pat_load and a completing bit: the load wins, and no match is produced.
- Saturation: match_cnt stops at all-ones and does not wrap.

## Test plan
- **Reset:** drive rst = 0 for 2 edges, then release. Required: str_out = 000, match = 0, match_cnt = 0; stream 1,1,0 (valid) then gives a match pulse at the 3rd edge, proving pat_reg = 110.
- **Stall tolerance:** N = 3, pattern 110, stream 1, (3 cycles in_valid = 0), 1, 0. Required: exactly one match, one cycle after the final 0 is sampled; str_out holds 001 during the stall.
- **Overlap mode:** N = 4, pattern 1010, stream 1,0,1,0,1,0,1 continuous valid.
  - overlap = 1: matches at bits 4 and 6, match_cnt = 2.
  - overlap = 0: match at bit 4 only, match_cnt = 1.
- **pat_load collision:** with hist = 011 and pattern 110, assert pat_load (pattern = 011) together with a completing str_in = 0. Required: no match that edge. Then stream 0,1,1 gives a match on the 3rd bit.
- **Counter saturation and clear:** CNT_W = 2, pattern 11, overlap = 1, stream of 6 ones gives 5 hits. Required: match_cnt = 3 after the 3rd hit and stays 3. Then cnt_clr together with a hit gives match_cnt = 1.
- **Reset mid-operation:** N = 3, pattern 110, stream 1,1, then rst = 0 for one edge, then 0,1,1,0. Required: no match on the 0 right after reset; a match after the final 0.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// Serial bit-pattern detector: compares the last N accepted bits against a
// loadable pattern, with overlapping/non-overlapping hits and a saturating hit count.
module serial_pattern_detector #(
    parameter int             N       = 3,
    parameter int             CNT_W   = 8,
    parameter logic [N-1:0]   PAT_RST = N'(3'b110)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             str_in,
    input  logic             in_valid,
    input  logic [N-1:0]     pattern,
    input  logic             pat_load,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic [N-1:0]     str_out,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int               FW       = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(N);
    localparam logic [FW-1:0]    FILL_HIT = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [N-1:0]     hist_q, hist_d;
    logic [N-1:0]     pat_q, pat_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     shifted;
    logic             hit;

    always_comb begin
        shifted = {hist_q[N-2:0], str_in};
        // fill tracks how many history bits are fresh enough to take part in a hit
        hit     = in_valid && !pat_load && (fill_q >= FILL_HIT) && (shifted == pat_q);

        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        match_d = hit;
        cnt_d   = cnt_q;

        if (in_valid) begin
            hist_d = shifted;
            if (hit && !overlap)
                fill_d = '0;
            else if (fill_q != FILL_MAX)
                fill_d = fill_q + FW'(1);
        end

        // a load restarts the fill even without a valid bit, so the new pattern
        // only ever matches N fresh bits
        if (pat_load) begin
            pat_d  = pattern;
            fill_d = '0;
        end

        if (cnt_clr)
            cnt_d = hit ? CNT_W'(1) : '0;
        else if (hit && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q  <= '0;
            pat_q   <= PAT_RST;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign str_out   = hist_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: three instances (N=3, N=4, N=2/CNT_W=2)
// driven from scenario tasks; expected hit/count values are queued per edge.
module tb_serial_pattern_detector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: N=3 pattern 110; instance 1: N=4 pattern 1010; instance 2: N=2, CNT_W=2, pattern 11
    logic       a_rst = 0, a_in = 0, a_vld = 0, a_ld = 0, a_ov = 1, a_clr = 0;
    logic [2:0] a_pat = 0, a_out;
    logic       a_m;
    logic [7:0] a_cnt;
    logic       b_rst = 0, b_in = 0, b_vld = 0, b_ld = 0, b_ov = 1, b_clr = 0;
    logic [3:0] b_pat = 0, b_out;
    logic       b_m;
    logic [7:0] b_cnt;
    logic       c_rst = 0, c_in = 0, c_vld = 0, c_ld = 0, c_ov = 1, c_clr = 0;
    logic [1:0] c_pat = 0, c_out;
    logic       c_m;
    logic [1:0] c_cnt;

    serial_pattern_detector #(.N(3), .CNT_W(8), .PAT_RST(3'b110)) u_a (
        .clk(clk), .rst(a_rst), .str_in(a_in), .in_valid(a_vld), .pattern(a_pat),
        .pat_load(a_ld), .overlap(a_ov), .cnt_clr(a_clr),
        .str_out(a_out), .match(a_m), .match_cnt(a_cnt));
    serial_pattern_detector #(.N(4), .CNT_W(8), .PAT_RST(4'b1010)) u_b (
        .clk(clk), .rst(b_rst), .str_in(b_in), .in_valid(b_vld), .pattern(b_pat),
        .pat_load(b_ld), .overlap(b_ov), .cnt_clr(b_clr),
        .str_out(b_out), .match(b_m), .match_cnt(b_cnt));
    serial_pattern_detector #(.N(2), .CNT_W(2), .PAT_RST(2'b11)) u_c (
        .clk(clk), .rst(c_rst), .str_in(c_in), .in_valid(c_vld), .pattern(c_pat),
        .pat_load(c_ld), .overlap(c_ov), .cnt_clr(c_clr),
        .str_out(c_out), .match(c_m), .match_cnt(c_cnt));

    typedef struct { logic m; int cnt; } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    function automatic logic get_m(input int inst);
        case (inst)
            0: return a_m;
            1: return b_m;
            default: return c_m;
        endcase
    endfunction

    function automatic int get_cnt(input int inst);
        case (inst)
            0: return int'(a_cnt);
            1: return int'(b_cnt);
            default: return int'(c_cnt);
        endcase
    endfunction

    // apply one edge of stimulus to an instance, return #1 after the edge
    task automatic drive(input int inst, input logic v, input logic b, input logic ld,
                         input logic [3:0] p, input logic ov, input logic clr);
        case (inst)
            0: begin a_vld = v; a_in = b; a_ld = ld; a_pat = p[2:0]; a_ov = ov; a_clr = clr; end
            1: begin b_vld = v; b_in = b; b_ld = ld; b_pat = p;      b_ov = ov; b_clr = clr; end
            default: begin c_vld = v; c_in = b; c_ld = ld; c_pat = p[1:0]; c_ov = ov; c_clr = clr; end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset(input int inst);
        case (inst)
            0: begin a_rst = 0; a_vld = 1; a_in = 1; end
            1: begin b_rst = 0; b_vld = 1; b_in = 1; end
            default: begin c_rst = 0; c_vld = 1; c_in = 1; end
        endcase
        @(posedge clk); #1;
        a_rst = 1; b_rst = 1; c_rst = 1;
        a_vld = 0; b_vld = 0; c_vld = 0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (a_out !== 3'b000 || a_m !== 1'b0 || a_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_a: str_out=%b match=%b cnt=%0d required 000/0/0", a_out, a_m, a_cnt);
        end
        checks++;
        if (b_m !== 1'b0 || b_cnt !== 8'd0 || c_m !== 1'b0 || c_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_bc: b_m=%b b_cnt=%0d c_m=%b c_cnt=%0d required all 0", b_m, b_cnt, c_m, c_cnt);
        end
        a_rst = 1; b_rst = 1; c_rst = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{m: (i == 2), cnt: (i == 2) ? 1 : 0});
            drive(0, 1'b1, (i < 2), 1'b0, 4'd0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (get_m(0) !== e.m || get_cnt(0) != e.cnt) begin
                errors++;
                $display("FAIL reset_pat bit%0d: match=%b cnt=%0d required %b/%0d", i, get_m(0), get_cnt(0), e.m, e.cnt);
            end
        end
        checks++;
        if (a_out !== 3'b110) begin
            errors++;
            $display("FAIL reset_hist: str_out=%b required 110", a_out);
        end
    endtask

    task automatic test_stall;
        logic [5:0] vld = 6'b110001; // index 0 first
        logic [5:0] bits = 6'b010001;
        pulse_reset(0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{m: (i == 5), cnt: (i == 5) ? 1 : 0});
            drive(0, vld[i], bits[i], 1'b0, 4'd0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (get_m(0) !== e.m || get_cnt(0) != e.cnt) begin
                errors++;
                $display("FAIL stall step%0d: match=%b cnt=%0d required %b/%0d", i, get_m(0), get_cnt(0), e.m, e.cnt);
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (a_out !== 3'b001) begin
                    errors++;
                    $display("FAIL stall_hold step%0d: str_out=%b required 001", i, a_out);
                end
            end
        end
    endtask

    task automatic test_overlap;
        logic [6:0] bits = 7'b1010101; // bits 1,0,1,0,1,0,1 in order
        logic [6:0] hit1 = 7'b0101000; // hits at bits 4 and 6 (index 3,5)
        int cnt;
        for (int ov = 1; ov >= 0; ov--) begin
            pulse_reset(1);
            cnt = 0;
            for (int i = 0; i < 7; i++) begin
                logic h;
                h = (ov == 1) ? hit1[i] : (i == 3);
                if (h) cnt++;
                exp_q.push_back('{m: h, cnt: cnt});
                drive(1, 1'b1, bits[6-i], 1'b0, 4'd0, ov[0], 1'b0);
                e = exp_q.pop_front();
                checks++;
                if (get_m(1) !== e.m || get_cnt(1) != e.cnt) begin
                    errors++;
                    $display("FAIL overlap%0d bit%0d: match=%b cnt=%0d required %b/%0d", ov, i + 1, get_m(1), get_cnt(1), e.m, e.cnt);
                end
            end
        end
    endtask

    task automatic test_pat_load;
        logic [6:0] bits = 7'b1100110; // 0,1,1, load+0, 0,1,1 (index 0 first)
        logic [6:0] hits = 7'b1000000;
        pulse_reset(0);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{m: hits[i], cnt: hits[i] ? 1 : 0});
            drive(0, 1'b1, bits[i], (i == 3), 4'b0011, 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (get_m(0) !== e.m || get_cnt(0) != e.cnt) begin
                errors++;
                $display("FAIL pat_load step%0d: match=%b cnt=%0d required %b/%0d", i, get_m(0), get_cnt(0), e.m, e.cnt);
            end
        end
        checks++;
        if (a_out !== 3'b011) begin
            errors++;
            $display("FAIL pat_load_hist: str_out=%b required 011", a_out);
        end
    endtask

    task automatic test_back_to_back;
        int cnt_tab[6] = '{0, 1, 2, 3, 3, 3};
        pulse_reset(2);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{m: (i > 0), cnt: cnt_tab[i]});
            drive(2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (get_m(2) !== e.m || get_cnt(2) != e.cnt) begin
                errors++;
                $display("FAIL saturate bit%0d: match=%b cnt=%0d required %b/%0d", i + 1, get_m(2), get_cnt(2), e.m, e.cnt);
            end
        end
        exp_q.push_back('{m: 1'b1, cnt: 1});
        exp_q.push_back('{m: 1'b0, cnt: 0});
        drive(2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (get_m(2) !== e.m || get_cnt(2) != e.cnt) begin
            errors++;
            $display("FAIL clr_hit: match=%b cnt=%0d required %b/%0d", get_m(2), get_cnt(2), e.m, e.cnt);
        end
        drive(2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (get_m(2) !== e.m || get_cnt(2) != e.cnt) begin
            errors++;
            $display("FAIL clr_nohit: match=%b cnt=%0d required %b/%0d", get_m(2), get_cnt(2), e.m, e.cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] bits = 4'b0110; // 0,1,1,0 (index 0 first)
        pulse_reset(0);
        drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        pulse_reset(0);
        checks++;
        if (a_out !== 3'b000 || a_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_state: str_out=%b cnt=%0d required 000/0", a_out, a_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{m: (i == 3), cnt: (i == 3) ? 1 : 0});
            drive(0, 1'b1, bits[i], 1'b0, 4'd0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (get_m(0) !== e.m || get_cnt(0) != e.cnt) begin
                errors++;
                $display("FAIL reset_mid bit%0d: match=%b cnt=%0d required %b/%0d", i, get_m(0), get_cnt(0), e.m, e.cnt);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stall();
        test_overlap();
        test_pat_load();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
